// File: rtl/dev_bus_bridge.sv
// dev_bus_bridge: CPU-to-timer peripheral bus initiator with registered HWInt[7:2] vector.
// Optional bus-error reporting (unmapped/misaligned) is enabled by defining BRIDGE_BUSERR_EN.
`timescale 1ns/1ps
`default_nettype none

module dev_bus_bridge #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_din,
  output logic        dev0_we,
  output logic        dev1_we,
  input  logic [31:0] dev0_dout,
  input  logic [31:0] dev1_dout,
  input  logic        dev0_int,
  input  logic        dev1_int,
  input  logic [3:0]  ext_int,
  output logic [5:0]  hwint,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        sel0_q, sel0_d;
  logic        sel1_q, sel1_d;
  logic        err_q, err_d;
  logic [1:0]  dev_addr_q, dev_addr_d;
  logic [31:0] dev_din_q, dev_din_d;
  logic [31:0] rdata_q, rdata_d;
  logic [5:0]  hwint_q;

  logic hit0;
  logic hit1;
  logic bad_access;

  assign hit0 = (cpu_addr[31:4] == DEV0_BASE[31:4]);
  assign hit1 = (cpu_addr[31:4] == DEV1_BASE[31:4]);

`ifdef BRIDGE_BUSERR_EN
  assign bad_access = (cpu_addr[1:0] != 2'b00) | ~(hit0 | hit1);
`else
  // Byte offset is simply dropped; the access goes to the decoded word.
  logic addr_lo_unused;
  assign addr_lo_unused = ^cpu_addr[1:0];
  assign bad_access     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    sel0_d     = sel0_q;
    sel1_d     = sel1_q;
    err_d      = err_q;
    dev_addr_d = dev_addr_q;
    dev_din_d  = dev_din_q;
    rdata_d    = rdata_q;
    cpu_ack    = 1'b0;
    cpu_err    = 1'b0;
    dev0_we    = 1'b0;
    dev1_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d       = cpu_we;
          sel0_d     = hit0 & ~bad_access;
          sel1_d     = hit1 & ~bad_access;
          err_d      = bad_access;
          dev_addr_d = cpu_addr[3:2];
          dev_din_d  = cpu_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        dev0_we = we_q & sel0_q;
        dev1_we = we_q & sel1_q;
        // Writes clear the read register so a stale load value never lingers.
        if (we_q)        rdata_d = 32'h0;
        else if (sel0_q) rdata_d = dev0_dout;
        else if (sel1_q) rdata_d = dev1_dout;
        else             rdata_d = 32'h0;
        state_d = RESP;
      end
      RESP: begin
        cpu_ack = 1'b1;
        cpu_err = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      sel0_q     <= 1'b0;
      sel1_q     <= 1'b0;
      err_q      <= 1'b0;
      dev_addr_q <= 2'b00;
      dev_din_q  <= 32'h0;
      rdata_q    <= 32'h0;
      hwint_q    <= 6'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      sel0_q     <= sel0_d;
      sel1_q     <= sel1_d;
      err_q      <= err_d;
      dev_addr_q <= dev_addr_d;
      dev_din_q  <= dev_din_d;
      rdata_q    <= rdata_d;
      hwint_q    <= {ext_int, dev1_int, dev0_int};
    end
  end

  assign cpu_rdata = rdata_q;
  assign dev_addr  = dev_addr_q;
  assign dev_din   = dev_din_q;
  assign hwint     = hwint_q;
  assign irq       = |hwint_q;

endmodule

`default_nettype wire

// File: tb/tb_dev_bus_bridge.sv
// tb_dev_bus_bridge: directed self-checking bench for dev_bus_bridge.
// Expectations follow BRIDGE_BUSERR_EN when the macro is defined for the build.
`timescale 1ns/1ps
`default_nettype none

module tb_dev_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic [1:0]  dev_addr;
  logic [31:0] dev_din;
  logic        dev0_we;
  logic        dev1_we;
  logic [31:0] dev0_dout;
  logic [31:0] dev1_dout;
  logic        dev0_int;
  logic        dev1_int;
  logic [3:0]  ext_int;
  logic [5:0]  hwint;
  logic        irq;

  int total = 0;
  int bad   = 0;

`ifdef BRIDGE_BUSERR_EN
  localparam logic        EXP_UNMAP_ERR = 1'b1;
  localparam logic        EXP_MIS_ERR   = 1'b1;
  localparam logic [31:0] EXP_MIS_RD    = 32'h0;
  localparam logic        EXP_MIS_WE0   = 1'b0;
`else
  localparam logic        EXP_UNMAP_ERR = 1'b0;
  localparam logic        EXP_MIS_ERR   = 1'b0;
  localparam logic [31:0] EXP_MIS_RD    = 32'h5000_0001;
  localparam logic        EXP_MIS_WE0   = 1'b1;
`endif

  dev_bus_bridge dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .dev_addr  (dev_addr),
    .dev_din   (dev_din),
    .dev0_we   (dev0_we),
    .dev1_we   (dev1_we),
    .dev0_dout (dev0_dout),
    .dev1_dout (dev1_dout),
    .dev0_int  (dev0_int),
    .dev1_int  (dev1_int),
    .ext_int   (ext_int),
    .hwint     (hwint),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Timer register files: combinational on the word select
  assign dev0_dout = 32'hA000_0000 | {30'd0, dev_addr};
  assign dev1_dout = (dev_addr == 2'b10) ? 32'h0000_1234 : (32'h5000_0000 | {30'd0, dev_addr});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: accepted at the next edge, ACCESS after it, ack one cycle later.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ewe0, input logic ewe1,
                        input logic [31:0] erdata, input logic eerr, input logic hold);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    tick();
    chk({tag, ".acc_ack"},  cpu_ack,  1'b0);
    chk({tag, ".acc_we0"},  dev0_we,  ewe0);
    chk({tag, ".acc_we1"},  dev1_we,  ewe1);
    chk({tag, ".acc_addr"}, dev_addr, addr[3:2]);
    chk({tag, ".acc_din"},  dev_din,  wdata);
    cpu_we    = ~we;
    cpu_addr  = 32'h0000_7F1C;
    cpu_wdata = 32'hDEAD_BEEF;
    tick();
    chk({tag, ".rsp_ack"},  cpu_ack,  1'b1);
    chk({tag, ".rsp_we0"},  dev0_we,  1'b0);
    chk({tag, ".rsp_we1"},  dev1_we,  1'b0);
    chk({tag, ".rsp_addr"}, dev_addr, addr[3:2]);
    chk({tag, ".rsp_din"},  dev_din,  wdata);
    chk({tag, ".rsp_err"},  cpu_err,  eerr);
    if (!we) chk({tag, ".rsp_rdata"}, cpu_rdata, erdata);
    if (!hold) cpu_req = 1'b0;
    tick();
    chk({tag, ".idle_ack"}, cpu_ack, 1'b0);
    chk({tag, ".idle_we0"}, dev0_we, 1'b0);
    chk({tag, ".idle_we1"}, dev1_we, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dev0_int = 1'b0; dev1_int = 1'b0; ext_int = 4'h0;
    tick(); tick();
    chk("rst.ack",   cpu_ack,   1'b0);
    chk("rst.err",   cpu_err,   1'b0);
    chk("rst.rdata", cpu_rdata, 32'h0);
    chk("rst.daddr", dev_addr,  2'b00);
    chk("rst.din",   dev_din,   32'h0);
    chk("rst.we0",   dev0_we,   1'b0);
    chk("rst.we1",   dev1_we,   1'b0);
    chk("rst.hwint", hwint,     6'b0);
    chk("rst.irq",   irq,       1'b0);
    reset = 1'b0;
    tick();

    access("st7F00",  1'b1, 32'h0000_7F00, 32'h9,          1'b1, 1'b0, 32'h0,          1'b0, 1'b0);
    access("ld7F18",  1'b0, 32'h0000_7F18, 32'h0,          1'b0, 1'b0, 32'h0000_1234,  1'b0, 1'b0);
    access("ld7F20",  1'b0, 32'h0000_7F20, 32'h0,          1'b0, 1'b0, 32'h0,          EXP_UNMAP_ERR, 1'b0);
    access("st7F30",  1'b1, 32'h0000_7F30, 32'h77,         1'b0, 1'b0, 32'h0,          EXP_UNMAP_ERR, 1'b0);
    access("b2b_st",  1'b1, 32'h0000_7F04, 32'hAA,         1'b1, 1'b0, 32'h0,          1'b0, 1'b1);
    access("b2b_ld",  1'b0, 32'h0000_7F08, 32'h55,         1'b0, 1'b0, 32'hA000_0002,  1'b0, 1'b0);
    access("ld7F00",  1'b0, 32'h0000_7F00, 32'h0,          1'b0, 1'b0, 32'hA000_0000,  1'b0, 1'b0);
    access("ld7F16m", 1'b0, 32'h0000_7F16, 32'h0,          1'b0, 1'b0, EXP_MIS_RD,     EXP_MIS_ERR, 1'b0);
    access("st7F01m", 1'b1, 32'h0000_7F01, 32'h3,          EXP_MIS_WE0, 1'b0, 32'h0,   EXP_MIS_ERR, 1'b0);
    access("st7F1C",  1'b1, 32'h0000_7F1C, 32'hCAFE_0001,  1'b0, 1'b1, 32'h0,          1'b0, 1'b0);

    dev0_int = 1'b1;
    chk("int.pre", hwint, 6'b0);
    tick();
    chk("int.d0",     hwint, 6'b000001);
    chk("int.d0_irq", irq,   1'b1);
    dev0_int = 1'b0; dev1_int = 1'b1;
    tick();
    chk("int.d1", hwint, 6'b000010);
    dev1_int = 1'b0; ext_int = 4'b1000;
    tick();
    chk("int.ext7",     hwint, 6'b100000);
    chk("int.ext7_irq", irq,   1'b1);
    ext_int = 4'b0000;
    tick();
    chk("int.clr",     hwint, 6'b0);
    chk("int.clr_irq", irq,   1'b0);

    ext_int = 4'hF;
    tick();
    chk("rmid.hw_pre", hwint, 6'b111100);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F10; cpu_wdata = 32'h5;
    tick();
    chk("rmid.we1_acc", dev1_we, 1'b1);
    reset = 1'b1;
    tick();
    chk("rmid.we0",   dev0_we,   1'b0);
    chk("rmid.we1",   dev1_we,   1'b0);
    chk("rmid.ack",   cpu_ack,   1'b0);
    chk("rmid.err",   cpu_err,   1'b0);
    chk("rmid.rdata", cpu_rdata, 32'h0);
    chk("rmid.daddr", dev_addr,  2'b00);
    chk("rmid.din",   dev_din,   32'h0);
    chk("rmid.hwint", hwint,     6'b0);
    chk("rmid.irq",   irq,       1'b0);
    reset = 1'b0; cpu_req = 1'b0; ext_int = 4'h0;
    tick();
    chk("rmid.ack1", cpu_ack, 1'b0);
    tick();
    chk("rmid.ack2", cpu_ack, 1'b0);
    chk("rmid.we1b", dev1_we, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
